// File: rtl/monitor_carga_pkg.sv
// Shared types and constants for the battery charge monitor.
// Level encodings, charge range, and default thresholds.
package monitor_carga_pkg;

  typedef enum logic [1:0] {
    NORMAL  = 2'b00,
    BAJA    = 2'b01,
    CRITICA = 2'b10
  } nivel_t;

  localparam int CARGA_W   = 5;
  localparam int CARGA_MAX = 30;

  localparam int N_MUESTRAS_DEF       = 4;
  localparam int UMBRAL_BAJA_DEF      = 12;
  localparam int UMBRAL_CRITICA_DEF   = 6;
  localparam int HISTERESIS_DEF       = 2;
  localparam int PERIODO_PARPADEO_DEF = 8;

  // The adder stage can report 31; clamp it to the physical maximum.
  function automatic logic [CARGA_W-1:0] saturar(input logic [CARGA_W-1:0] v);
    return (v > CARGA_W'(CARGA_MAX)) ? CARGA_W'(CARGA_MAX) : v;
  endfunction

endpackage

// File: rtl/monitor_carga_if.sv
// Sample input and level/alarm outputs of the charge monitor.
// master drives samples; slave is the monitor itself.
interface monitor_carga_if;
  import monitor_carga_pkg::*;

  logic [CARGA_W-1:0] carga_total;
  logic               muestra_valida;
  logic [CARGA_W-1:0] promedio;
  logic               promedio_valido;
  nivel_t             nivel;
  logic               alarma;

  modport master (
    output carga_total, muestra_valida,
    input  promedio, promedio_valido, nivel, alarma
  );

  modport slave (
    input  carga_total, muestra_valida,
    output promedio, promedio_valido, nivel, alarma
  );

endinterface

// File: rtl/promediador_carga.sv
// Block average of N_MUESTRAS saturated charge samples.
// promedio and its one-cycle valid pulse load on the edge accepting the last sample.
module promediador_carga
  import monitor_carga_pkg::*;
#(
  parameter int N_MUESTRAS = N_MUESTRAS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CARGA_W-1:0] carga_total,
  input  logic               muestra_valida,
  output logic [CARGA_W-1:0] promedio,
  output logic               promedio_valido
);

  localparam int LOG2N = $clog2(N_MUESTRAS);
  localparam int ACC_W = $clog2(N_MUESTRAS * CARGA_MAX + 1);

  logic [ACC_W-1:0]   acc_q, acc_d, suma;
  logic [LOG2N-1:0]   cnt_q, cnt_d;
  logic [CARGA_W-1:0] prom_q, prom_d;
  logic               valido_q, valido_d;

  always_comb begin
    suma     = acc_q + ACC_W'(saturar(carga_total));
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    prom_d   = prom_q;
    valido_d = 1'b0;
    if (muestra_valida) begin
      if (cnt_q == LOG2N'(N_MUESTRAS - 1)) begin
        // The closing sample is folded in here, so the window restarts empty.
        prom_d   = CARGA_W'(suma >> LOG2N);
        valido_d = 1'b1;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        acc_d = suma;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      prom_q   <= '0;
      valido_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      prom_q   <= prom_d;
      valido_q <= valido_d;
    end
  end

  assign promedio        = prom_q;
  assign promedio_valido = valido_q;

endmodule

// File: rtl/monitor_carga.sv
// Charge monitor: averages samples, classifies NORMAL/BAJA/CRITICA with hysteresis,
// and blinks alarma while CRITICA. nivel follows promedio_valido by one cycle.
module monitor_carga
  import monitor_carga_pkg::*;
#(
  parameter int N_MUESTRAS       = N_MUESTRAS_DEF,
  parameter int UMBRAL_BAJA      = UMBRAL_BAJA_DEF,
  parameter int UMBRAL_CRITICA   = UMBRAL_CRITICA_DEF,
  parameter int HISTERESIS       = HISTERESIS_DEF,
  parameter int PERIODO_PARPADEO = PERIODO_PARPADEO_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  monitor_carga_if.slave  bus
);

  localparam int PARP_W = (PERIODO_PARPADEO > 1) ? $clog2(PERIODO_PARPADEO) : 1;

  localparam logic [CARGA_W-1:0] LIM_CRIT      = CARGA_W'(UMBRAL_CRITICA);
  localparam logic [CARGA_W-1:0] LIM_BAJA      = CARGA_W'(UMBRAL_BAJA);
  localparam logic [CARGA_W-1:0] SALIDA_CRIT   = CARGA_W'(UMBRAL_CRITICA + HISTERESIS);
  localparam logic [CARGA_W-1:0] SALIDA_BAJA   = CARGA_W'(UMBRAL_BAJA + HISTERESIS);

  logic [CARGA_W-1:0] promedio;
  logic               promedio_valido;

  nivel_t             nivel_q, nivel_d;
  logic               alarma_q, alarma_d;
  logic [PARP_W-1:0]  parp_q, parp_d;

  promediador_carga #(
    .N_MUESTRAS (N_MUESTRAS)
  ) u_promediador (
    .clk             (clk),
    .rst_n           (rst_n),
    .carga_total     (bus.carga_total),
    .muestra_valida  (bus.muestra_valida),
    .promedio        (promedio),
    .promedio_valido (promedio_valido)
  );

  always_comb begin
    nivel_d  = nivel_q;
    alarma_d = alarma_q;
    parp_d   = parp_q;

    if (promedio_valido) begin
      case (nivel_q)
        NORMAL: begin
          if (promedio < LIM_CRIT)      nivel_d = CRITICA;
          else if (promedio < LIM_BAJA) nivel_d = BAJA;
        end
        BAJA: begin
          if (promedio < LIM_CRIT)          nivel_d = CRITICA;
          else if (promedio >= SALIDA_BAJA) nivel_d = NORMAL;
        end
        CRITICA: begin
          if (promedio >= SALIDA_BAJA)      nivel_d = NORMAL;
          else if (promedio >= SALIDA_CRIT) nivel_d = BAJA;
        end
        default: nivel_d = NORMAL;
      endcase
    end

    // Alarm tracks the next level so entry and exit land on the same edge as nivel.
    if (nivel_d == CRITICA) begin
      if (nivel_q != CRITICA) begin
        alarma_d = 1'b1;
        parp_d   = '0;
      end else if (parp_q == PARP_W'(PERIODO_PARPADEO - 1)) begin
        alarma_d = ~alarma_q;
        parp_d   = '0;
      end else begin
        parp_d = parp_q + 1'b1;
      end
    end else begin
      alarma_d = 1'b0;
      parp_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nivel_q  <= NORMAL;
      alarma_q <= 1'b0;
      parp_q   <= '0;
    end else begin
      nivel_q  <= nivel_d;
      alarma_q <= alarma_d;
      parp_q   <= parp_d;
    end
  end

  assign bus.promedio        = promedio;
  assign bus.promedio_valido = promedio_valido;
  assign bus.nivel           = nivel_q;
  assign bus.alarma          = alarma_q;

endmodule

// File: tb/tb_monitor_carga.sv
// Scoreboard bench for monitor_carga: each sample window queues its expected
// average, next level and alarm behaviour; a monitor checks them on each pulse.
module tb_monitor_carga;
  import monitor_carga_pkg::*;

  logic clk;
  logic rst_n;

  monitor_carga_if bus ();

  monitor_carga dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // modo 0: alarma must read 0 after the update; modo 1: entering CRITICA, check blink.
  typedef struct {
    int prom;
    int niv;
    int modo;
  } esperado_t;

  esperado_t cola[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nombre, input int actual, input int requerido);
    checks++;
    if (actual !== requerido) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nombre, actual, requerido, $time);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic enviar(input int v, input int hueco);
    bus.carga_total    = 5'(v);
    bus.muestra_valida = 1'b1;
    @(negedge clk);
    bus.muestra_valida = 1'b0;
    repeat (hueco) @(negedge clk);
  endtask

  task automatic ventana(input int s0, input int s1, input int s2, input int s3,
                         input bit con_huecos, input int e_prom, input int e_niv,
                         input int modo, input int reposo);
    int s[4];
    esperado_t e;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    e.prom = e_prom;
    e.niv  = e_niv;
    e.modo = modo;
    cola.push_back(e);
    for (int i = 0; i < 4; i++) enviar(s[i], con_huecos ? i : 0);
    repeat (reposo) @(negedge clk);
  endtask

  task automatic chk_reset(input string etiqueta);
    chk({etiqueta, "_promedio"}, int'(bus.promedio), 0);
    chk({etiqueta, "_valido"},   int'(bus.promedio_valido), 0);
    chk({etiqueta, "_nivel"},    int'(bus.nivel), int'(NORMAL));
    chk({etiqueta, "_alarma"},   int'(bus.alarma), 0);
  endtask

  // Monitor: pops and compares whenever the DUT presents a new average.
  initial begin
    esperado_t e;
    forever begin
      @(negedge clk);
      if (bus.promedio_valido === 1'b1) begin
        if (cola.size() == 0) begin
          chk("pulso_espurio", 1, 0);
        end else begin
          e = cola.pop_front();
          chk("promedio", int'(bus.promedio), e.prom);
          @(negedge clk);
          chk("pulso_un_ciclo", int'(bus.promedio_valido), 0);
          chk("nivel", int'(bus.nivel), e.niv);
          if (e.modo == 1) begin
            chk("alarma_entrada", int'(bus.alarma), 1);
            for (int k = 1; k <= 16; k++) begin
              @(negedge clk);
              chk($sformatf("parpadeo_%0d", k), int'(bus.alarma),
                  (k < 8) ? 1 : ((k < 16) ? 0 : 1));
            end
          end else begin
            chk("alarma_apagada", int'(bus.alarma), 0);
          end
        end
      end
    end
  end

  initial begin
    rst_n              = 1'b0;
    bus.carga_total    = '0;
    bus.muestra_valida = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    ventana(20, 20, 20, 20, 1'b0, 20, int'(NORMAL),  0, 3);
    ventana(10, 10, 10, 10, 1'b0, 10, int'(BAJA),    0, 3);
    ventana(13, 13, 13, 13, 1'b0, 13, int'(BAJA),    0, 3);
    ventana(14, 14, 14, 14, 1'b0, 14, int'(NORMAL),  0, 3);
    ventana( 4,  4,  4,  4, 1'b0,  4, int'(CRITICA), 1, 30);
    ventana( 8,  8,  8,  8, 1'b0,  8, int'(BAJA),    0, 3);
    ventana(31, 31, 31, 31, 1'b1, 30, int'(NORMAL),  0, 3);
    ventana( 3,  4,  4,  4, 1'b0,  3, int'(CRITICA), 1, 30);

    // Partial window interrupted by reset must be discarded.
    enviar(5, 0);
    enviar(5, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("reset_medio");
    rst_n = 1'b1;
    @(negedge clk);
    ventana(20, 20, 20, 20, 1'b0, 20, int'(NORMAL), 0, 3);

    for (int i = 0; i < 100 && cola.size() != 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("cola_vacia", cola.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
